sdram_arbiter: RTL and testbench

Central command-bus arbiter for the SDRAM controller. Sits between the per-function sequencers (power-up init, auto-refresh, burst write, burst read) and the SDRAM pins, granting the single command/address bus to one sequencer at a time. Priority is refresh > write/read, with write and read alternating when both are pending. A watchdog forces recovery if a granted sequencer never signals completion.

---
 rtl/sdram_arbiter_if.sv | 43 ++++
 rtl/sdram_arbiter.sv | 130 +++++++++++++
 tb/tb_sdram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Command-bus bundle between the SDRAM sequencers and the arbiter.
// master = sequencer side, slave = arbiter side.
interface sdram_arbiter_if;
  logic        flag_init_end;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        ref_req;
  logic        flag_ref_end;
  logic [3:0]  aref_cmd;
  logic [11:0] aref_addr;
  logic        wr_req;
  logic        rd_req;
  logic        flag_wr_end;
  logic        flag_rd_end;
  logic [3:0]  wr_cmd;
  logic [3:0]  rd_cmd;
  logic [11:0] wr_addr;
  logic [11:0] rd_addr;
  logic        ref_en;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic        timeout_err;

  modport master (
    output flag_init_end, init_cmd, init_addr,
    output ref_req, flag_ref_end, aref_cmd, aref_addr,
    output wr_req, rd_req, flag_wr_end, flag_rd_end,
    output wr_cmd, rd_cmd, wr_addr, rd_addr,
    input  ref_en, wr_en, rd_en,
    input  sdram_cmd, sdram_addr, timeout_err
  );

  modport slave (
    input  flag_init_end, init_cmd, init_addr,
    input  ref_req, flag_ref_end, aref_cmd, aref_addr,
    input  wr_req, rd_req, flag_wr_end, flag_rd_end,
    input  wr_cmd, rd_cmd, wr_addr, rd_addr,
    output ref_en, wr_en, rd_en,
    output sdram_cmd, sdram_addr, timeout_err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: refresh first, write/read alternate,
// watchdog releases a grant that never reports completion.
module sdram_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input logic           CLK,
  input logic           RSTn,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ
  } state_e;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             last_rd_q, last_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ref_win, wr_win, rd_win;
  logic in_grant, end_hit, to_hit;

  // last_rd_q=1 means read was served last, so write wins a tie
  always_comb begin
    ref_win = bus.ref_req;
    wr_win  = !bus.ref_req && bus.wr_req &&
              (!bus.rd_req || last_rd_q);
    rd_win  = !bus.ref_req && bus.rd_req &&
              (!bus.wr_req || !last_rd_q);
  end

  always_comb begin
    in_grant = 1'b0;
    end_hit  = 1'b0;
    unique case (1'b1)
      state_q == S_AREF: begin
        in_grant = 1'b1;
        end_hit  = bus.flag_ref_end;
      end
      state_q == S_WRITE: begin
        in_grant = 1'b1;
        end_hit  = bus.flag_wr_end;
      end
      state_q == S_READ: begin
        in_grant = 1'b1;
        end_hit  = bus.flag_rd_end;
      end
      default: ;
    endcase
    to_hit = in_grant && (cnt_q == TO_LAST);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_INIT;
      last_rd_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    cnt_d     = '0;
    unique case (state_q)
      S_INIT:
        if (bus.flag_init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        unique case (1'b1)
          ref_win: state_d = S_AREF;
          wr_win: begin
            state_d   = S_WRITE;
            last_rd_d = 1'b0;
          end
          rd_win: begin
            state_d   = S_READ;
            last_rd_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (end_hit || to_hit) state_d = S_ARBIT;
      end
    endcase
  end

  always_comb begin
    bus.ref_en      = 1'b0;
    bus.wr_en       = 1'b0;
    bus.rd_en       = 1'b0;
    bus.timeout_err = to_hit && !end_hit;
    bus.sdram_cmd   = NOP;
    bus.sdram_addr  = '0;
    unique case (state_q)
      S_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
      end
      S_ARBIT: begin
        bus.ref_en = ref_win;
        bus.wr_en  = wr_win;
        bus.rd_en  = rd_win;
      end
      S_AREF: begin
        bus.sdram_cmd  = bus.aref_cmd;
        bus.sdram_addr = bus.aref_addr;
      end
      S_WRITE: begin
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_addr = bus.wr_addr;
      end
      S_READ: begin
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_addr = bus.rd_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with TIMEOUT=16.
// Each sequencer drives a distinct command/address so bus ownership is visible.
module tb_sdram_arbiter;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] CI   = 4'b0010;
  localparam logic [3:0] CA   = 4'b0001;
  localparam logic [3:0] CW   = 4'b0100;
  localparam logic [3:0] CR   = 4'b0101;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;

  sdram_arbiter_if bus ();

  sdram_arbiter #(.TIMEOUT(16), .CNT_W(10)) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.flag_init_end = 1'b0;
    bus.init_cmd  = CI;
    bus.init_addr = 12'h111;
    bus.ref_req = 1'b0;
    bus.flag_ref_end = 1'b0;
    bus.aref_cmd  = CA;
    bus.aref_addr = 12'h222;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.flag_wr_end = 1'b0;
    bus.flag_rd_end = 1'b0;
    bus.wr_cmd  = CW;
    bus.rd_cmd  = CR;
    bus.wr_addr = 12'h333;
    bus.rd_addr = 12'h444;
    #2;
    n_cmp++;
    if (bus.sdram_cmd !== CI || bus.sdram_addr !== 12'h111) begin
      n_bad++;
      $display("FAIL reset_bus: got %h/%h want %h/111",
               bus.sdram_cmd, bus.sdram_addr, CI);
    end
    n_cmp++;
    if ({bus.ref_en, bus.wr_en, bus.rd_en, bus.timeout_err} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_en: got %b want 0000",
               {bus.ref_en, bus.wr_en, bus.rd_en, bus.timeout_err});
    end
    tick();
    tick();
    rstn = 1'b1;
    bus.ref_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      n_cmp++;
      if (bus.sdram_cmd !== CI ||
          {bus.ref_en, bus.wr_en, bus.rd_en} !== 3'b0) begin
        n_bad++;
        $display("FAIL init_hold[%0d]: got cmd %h en %b want %h 000", i,
                 bus.sdram_cmd, {bus.ref_en, bus.wr_en, bus.rd_en}, CI);
      end
    end
    bus.ref_req = 1'b0;
    bus.flag_init_end = 1'b1;
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== CI) begin
      n_bad++;
      $display("FAIL init_last: got %h want %h", bus.sdram_cmd, CI);
    end
    tick();
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== NOP || bus.sdram_addr !== 12'h000 ||
        {bus.ref_en, bus.wr_en, bus.rd_en} !== 3'b0) begin
      n_bad++;
      $display("FAIL arbit_idle: got %h/%h en %b want 7/000 000",
               bus.sdram_cmd, bus.sdram_addr,
               {bus.ref_en, bus.wr_en, bus.rd_en});
    end
  endtask

  task automatic test_priority;
    bus.ref_req = 1'b1;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ref_en, bus.wr_en, bus.rd_en} !== 3'b100) begin
      n_bad++;
      $display("FAIL prio_grant: got %b want 100",
               {bus.ref_en, bus.wr_en, bus.rd_en});
    end
    tick();
    bus.ref_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) bus.flag_ref_end = 1'b1;
      #1;
      n_cmp++;
      if (bus.sdram_cmd !== CA || bus.sdram_addr !== 12'h222 ||
          {bus.ref_en, bus.wr_en, bus.rd_en} !== 3'b0) begin
        n_bad++;
        $display("FAIL aref_bus[%0d]: got %h/%h en %b want %h/222 000", c,
                 bus.sdram_cmd, bus.sdram_addr,
                 {bus.ref_en, bus.wr_en, bus.rd_en}, CA);
      end
      if (c < 3) tick();
    end
    tick();
    bus.flag_ref_end = 1'b0;
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== NOP ||
        {bus.ref_en, bus.wr_en, bus.rd_en} !== 3'b010) begin
      n_bad++;
      $display("FAIL after_ref: got %h en %b want 7 010",
               bus.sdram_cmd, {bus.ref_en, bus.wr_en, bus.rd_en});
    end
  endtask

  // Entered in ARBIT with wr_en already granted and both requests held.
  task automatic test_back_to_back;
    logic [3:0] cur;
    logic [2:0] nxt;
    for (int k = 0; k < 4; k++) begin
      cur = (k % 2 == 0) ? CW : CR;
      tick();
      for (int c = 1; c <= 4; c++) begin
        if (c == 4) begin
          if (k % 2 == 0) bus.flag_wr_end = 1'b1;
          else bus.flag_rd_end = 1'b1;
        end
        #1;
        n_cmp++;
        if (bus.sdram_cmd !== cur) begin
          n_bad++;
          $display("FAIL b2b_burst[%0d.%0d]: got %h want %h",
                   k, c, bus.sdram_cmd, cur);
        end
        if (c < 4) tick();
      end
      tick();
      bus.flag_wr_end = 1'b0;
      bus.flag_rd_end = 1'b0;
      nxt = (k % 2 == 0) ? 3'b001 : 3'b010;
      #1;
      n_cmp++;
      if (bus.sdram_cmd !== NOP ||
          {bus.ref_en, bus.wr_en, bus.rd_en} !== nxt) begin
        n_bad++;
        $display("FAIL b2b_gap[%0d]: got %h en %b want 7 %b", k,
                 bus.sdram_cmd, {bus.ref_en, bus.wr_en, bus.rd_en}, nxt);
      end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== NOP) begin
      n_bad++;
      $display("FAIL b2b_idle: got %h want 7", bus.sdram_cmd);
    end
  endtask

  task automatic test_ignore_foreign;
    bus.wr_req = 1'b1;
    #1;
    n_cmp++;
    if (bus.wr_en !== 1'b1) begin
      n_bad++;
      $display("FAIL ign_grant: got %b want 1", bus.wr_en);
    end
    tick();
    bus.wr_req = 1'b0;
    bus.flag_rd_end = 1'b1;
    bus.flag_ref_end = 1'b1;
    tick();
    bus.flag_rd_end = 1'b0;
    bus.flag_ref_end = 1'b0;
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== CW) begin
      n_bad++;
      $display("FAIL ign_foreign: got %h want %h", bus.sdram_cmd, CW);
    end
    bus.flag_wr_end = 1'b1;
    tick();
    bus.flag_wr_end = 1'b0;
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== NOP) begin
      n_bad++;
      $display("FAIL ign_exit: got %h want 7", bus.sdram_cmd);
    end
  endtask

  task automatic test_timeout(input logic end_same);
    bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 16 && end_same) bus.flag_wr_end = 1'b1;
      #1;
      n_cmp++;
      if (bus.sdram_cmd !== CW ||
          bus.timeout_err !== (c == 16 && !end_same)) begin
        n_bad++;
        $display("FAIL timeout[%0d,%0b]: got cmd %h err %b want %h %b",
                 c, end_same, bus.sdram_cmd, bus.timeout_err,
                 CW, (c == 16 && !end_same));
      end
      tick();
    end
    bus.flag_wr_end = 1'b0;
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== NOP || bus.timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_exit[%0b]: got %h err %b want 7 0",
               end_same, bus.sdram_cmd, bus.timeout_err);
    end
  endtask

  task automatic test_reset_mid;
    bus.rd_req = 1'b1;
    #1;
    n_cmp++;
    if (bus.rd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_grant: got %b want 1", bus.rd_en);
    end
    tick();
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== CR || bus.sdram_addr !== 12'h444) begin
      n_bad++;
      $display("FAIL mid_read: got %h/%h want %h/444",
               bus.sdram_cmd, bus.sdram_addr, CR);
    end
    #1;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== CI || bus.sdram_addr !== 12'h111 ||
        {bus.ref_en, bus.wr_en, bus.rd_en, bus.timeout_err} !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got %h/%h en %b want %h/111 0000",
               bus.sdram_cmd, bus.sdram_addr,
               {bus.ref_en, bus.wr_en, bus.rd_en, bus.timeout_err}, CI);
    end
    tick();
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== CI || bus.rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_hold: got %h rd_en %b want %h 0",
               bus.sdram_cmd, bus.rd_en, CI);
    end
    rstn = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (bus.sdram_cmd !== NOP || bus.rd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_recover: got %h rd_en %b want 7 1",
               bus.sdram_cmd, bus.rd_en);
    end
    bus.rd_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_back_to_back();
    test_ignore_foreign();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
